// File: rtl/mips_boot_pkg.sv
// Shared types and frame constants for the MIPS instruction-memory boot loader.
package mips_boot_pkg;
    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int CSUM_W         = 8;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);
endpackage

// File: rtl/imem_word_assembler.sv
// Shifts frame bytes MSB-first into a 32-bit word; pulses word_valid on the last lane.
module imem_word_assembler
    import mips_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [23:0]       shift_q, shift_d;

    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        if (clear) begin
            lane_d  = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            lane_d  = lane_q + 1'b1;
            shift_d = {shift_q[15:0], byte_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

    // The fourth byte completes the word combinationally; the top registers it.
    assign word_valid = byte_valid & ~clear
                      & (lane_q == LANE_W'(BYTES_PER_WORD - 1));
    assign word       = {shift_q, byte_in};
endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader: writes big-endian words into IMEM, checks XOR csum,
// and releases the MIPS core only after a clean load.
module imem_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] words_loaded
);
    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [CSUM_W-1:0]   acc_q, acc_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [15:0]         wl_q, wl_d;

    logic        xfer;
    logic        asm_valid;
    logic [31:0] asm_word;
    logic [15:0] n_len;

    assign in_ready = ~load_start
                    & (state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM});
    assign xfer     = in_valid & in_ready;
    assign n_len    = {len_q[15:8], in_data};

    imem_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (reset),
        .clear      (load_start),
        .byte_valid (xfer & (state_q == S_DATA)),
        .byte_in    (in_data),
        .word_valid (asm_valid),
        .word       (asm_word)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wl_d    = wl_q;
        if (load_start) begin
            state_d = S_LEN_HI;
            len_d   = '0;
            acc_d   = '0;
            wl_d    = '0;
        end else begin
            if (xfer && state_q != S_CSUM) acc_d = acc_q ^ in_data;
            // words_loaded doubles as the index of the word being written.
            if (asm_valid) begin
                we_d    = 1'b1;
                wdata_d = asm_word;
                addr_d  = BASE_ADDR + {14'd0, wl_q, 2'b00};
                wl_d    = wl_q + 16'd1;
            end
            unique case (state_q)
                S_LEN_HI: if (xfer) begin
                    len_d   = {in_data, 8'h00};
                    state_d = S_LEN_LO;
                end
                S_LEN_LO: if (xfer) begin
                    len_d = n_len;
                    if ({1'b0, n_len} > DEPTH_L) state_d = S_ERR;
                    else if (n_len == 16'd0)     state_d = S_CSUM;
                    else                          state_d = S_DATA;
                end
                S_DATA: if (asm_valid && (wl_q + 16'd1 == len_q)) begin
                    state_d = S_CSUM;
                end
                S_CSUM: if (xfer) begin
                    state_d = (in_data == acc_q) ? S_DONE : S_ERR;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LEN_HI;
            len_q   <= '0;
            acc_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wl_q    <= wl_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = wl_q;
    assign load_done    = (state_q == S_DONE);
    assign load_err     = (state_q == S_ERR);
    assign cpu_hold     = (state_q != S_DONE);
endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader against a frame-level reference model.
module tb_imem_boot_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    logic [31:0] ex_a[$];
    logic [31:0] ex_d[$];
    bit          ex_done;
    bit          ex_err;
    int          ex_wl;
    logic [7:0]  frame[$];

    imem_boot_loader dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_a.push_back(imem_addr);
            wr_d.push_back(imem_wdata);
        end
    end

    // Frame-level model: length, big-endian words, XOR of all bytes but the last.
    task automatic build_model();
        int n;
        logic [7:0] cs;
        ex_a.delete();
        ex_d.delete();
        n = {frame[0], frame[1]};
        if (n > 64) begin
            ex_err = 1; ex_done = 0; ex_wl = 0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            ex_a.push_back(32'(4 * i));
            ex_d.push_back({frame[2+4*i], frame[3+4*i],
                            frame[4+4*i], frame[5+4*i]});
        end
        cs = 8'h00;
        for (int i = 0; i < frame.size() - 1; i++) cs ^= frame[i];
        ex_done = (frame[frame.size()-1] == cs);
        ex_err  = !ex_done;
        ex_wl   = n;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        w = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_byte_timeout byte=%02h in_ready=%b required 1", b, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_frame(input int max_gap, input int count);
        for (int i = 0; i < count; i++)
            send_byte(frame[i], (max_gap == 0) ? 0 : $urandom_range(max_gap, 0));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        wr_a.delete();
        wr_d.delete();
    endtask

    task automatic set_good_frame(input logic [7:0] cs);
        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                  8'hAC, 8'h08, 8'h00, 8'h04, cs};
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({cpu_hold, load_done, load_err, imem_we} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_flags got=%b required 1000", {cpu_hold, load_done, load_err, imem_we});
        end
        n_cmp++;
        if (imem_addr !== 32'h0 || imem_wdata !== 32'h0 || words_loaded !== 16'd0) begin
            n_err++;
            $display("FAIL reset_regs addr=%h wdata=%h wl=%0d required 0", imem_addr, imem_wdata, words_loaded);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready got=%b required 1", in_ready);
        end
    endtask

    task automatic test_good_frame(input int max_gap);
        pulse_start();
        set_good_frame(8'h8F);
        build_model();
        send_frame(max_gap, frame.size());
        repeat (2) @(negedge clk);
        n_cmp++;
        if (wr_a.size() != 2) begin
            n_err++;
            $display("FAIL good_nwrites got=%0d required 2", wr_a.size());
        end
        for (int i = 0; i < 2 && i < wr_a.size(); i++) begin
            n_cmp++;
            if (wr_a[i] !== ex_a[i] || wr_d[i] !== ex_d[i]) begin
                n_err++;
                $display("FAIL good_write%0d got=%h@%h required %h@%h", i, wr_d[i], wr_a[i], ex_d[i], ex_a[i]);
            end
        end
        n_cmp++;
        if ({load_done, load_err, cpu_hold} !== 3'b100 || words_loaded !== 16'd2) begin
            n_err++;
            $display("FAIL good_status done/err/hold=%b wl=%0d required 100 wl=2", {load_done, load_err, cpu_hold}, words_loaded);
        end
    endtask

    task automatic test_bad_csum();
        pulse_start();
        set_good_frame(8'h8E);
        build_model();
        send_frame(0, frame.size());
        repeat (2) @(negedge clk);
        n_cmp++;
        if (wr_a.size() != 2 || wr_d[0] !== 32'h2008_0005 || wr_d[1] !== 32'hAC08_0004) begin
            n_err++;
            $display("FAIL badcs_writes n=%0d required 2 writes 20080005,AC080004", wr_a.size());
        end
        n_cmp++;
        if ({load_done, load_err, cpu_hold, in_ready} !== 4'b0110) begin
            n_err++;
            $display("FAIL badcs_status done/err/hold/rdy=%b required 0110", {load_done, load_err, cpu_hold, in_ready});
        end
    endtask

    task automatic test_empty();
        pulse_start();
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(0, 3);
        @(negedge clk);
        n_cmp++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
            n_err++;
            $display("FAIL empty_done done=%b hold=%b required 1 0", load_done, cpu_hold);
        end
        @(negedge clk);
        n_cmp++;
        if (wr_a.size() != 0) begin
            n_err++;
            $display("FAIL empty_writes got=%0d required 0", wr_a.size());
        end
    endtask

    task automatic test_oversize();
        pulse_start();
        frame = '{8'h00, 8'h41};
        send_frame(0, 2);
        @(negedge clk);
        n_cmp++;
        if (load_err !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            n_err++;
            $display("FAIL over_err err=%b rdy=%b hold=%b required 1 0 1", load_err, in_ready, cpu_hold);
        end
        in_valid = 1'b1;
        in_data  = 8'h20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL over_ready%0d got=%b required 0", i, in_ready);
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (wr_a.size() != 0 || words_loaded !== 16'd0) begin
            n_err++;
            $display("FAIL over_writes n=%0d wl=%0d required 0 0", wr_a.size(), words_loaded);
        end
    endtask

    task automatic test_abort();
        pulse_start();
        set_good_frame(8'h8F);
        send_frame(0, 6);
        @(negedge clk);
        n_cmp++;
        if (words_loaded !== 16'd1) begin
            n_err++;
            $display("FAIL abort_pre_wl got=%0d required 1", words_loaded);
        end
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'hAC;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL abort_ready got=%b required 0", in_ready);
        end
        @(negedge clk);
        load_start = 1'b0;
        in_valid   = 1'b0;
        n_cmp++;
        if (words_loaded !== 16'd0 || cpu_hold !== 1'b1) begin
            n_err++;
            $display("FAIL abort_clear wl=%0d hold=%b required 0 1", words_loaded, cpu_hold);
        end
        wr_a.delete();
        wr_d.delete();
        send_frame(0, frame.size());
        repeat (2) @(negedge clk);
        n_cmp++;
        if (wr_a.size() != 2 || load_done !== 1'b1 || wr_a[1] !== 32'h4) begin
            n_err++;
            $display("FAIL abort_resend n=%0d done=%b required 2 writes done=1", wr_a.size(), load_done);
        end
    endtask

    task automatic test_reset_mid_data();
        pulse_start();
        set_good_frame(8'h8F);
        send_frame(2, 5);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (cpu_hold !== 1'b1 || imem_we !== 1'b0 || words_loaded !== 16'd0) begin
            n_err++;
            $display("FAIL rst_mid hold=%b we=%b wl=%0d required 1 0 0", cpu_hold, imem_we, words_loaded);
        end
        @(negedge clk);
        reset = 1'b1;
        wr_a.delete();
        wr_d.delete();
        test_good_frame(3);
    endtask

    task automatic test_random_frames();
        int n;
        for (int f = 0; f < 8; f++) begin
            pulse_start();
            n = $urandom_range(6, 0);
            frame = '{8'h00, 8'(n)};
            for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
            frame.push_back(8'h00);
            build_model();
            if ($urandom_range(1, 0) == 1) begin
                frame[frame.size()-1] = 8'h00;
                for (int i = 0; i < frame.size() - 1; i++)
                    frame[frame.size()-1] ^= frame[i];
            end else begin
                frame[frame.size()-1] = 8'($urandom);
            end
            build_model();
            send_frame(3, frame.size());
            repeat (2) @(negedge clk);
            n_cmp++;
            if (wr_a.size() != ex_a.size()) begin
                n_err++;
                $display("FAIL rnd%0d_nwrites got=%0d required %0d", f, wr_a.size(), ex_a.size());
            end
            for (int i = 0; i < ex_a.size() && i < wr_a.size(); i++) begin
                n_cmp++;
                if (wr_a[i] !== ex_a[i] || wr_d[i] !== ex_d[i]) begin
                    n_err++;
                    $display("FAIL rnd%0d_write%0d got=%h@%h required %h@%h", f, i, wr_d[i], wr_a[i], ex_d[i], ex_a[i]);
                end
            end
            n_cmp++;
            if (load_done !== ex_done || load_err !== ex_err || cpu_hold !== !ex_done
                || words_loaded !== 16'(ex_wl)) begin
                n_err++;
                $display("FAIL rnd%0d_status done=%b err=%b hold=%b wl=%0d required %b %b %b %0d",
                         f, load_done, load_err, cpu_hold, words_loaded, ex_done, ex_err, !ex_done, ex_wl);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_good_frame(0);
        test_bad_csum();
        test_empty();
        test_oversize();
        test_abort();
        test_reset_mid_data();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
